cycle_countdown: RTL
====================

# cycle_countdown

Loadable down-counter that sequences iterative datapaths (multiply/divide step counters, timeouts). A start pulse loads an initial count. The counter then decrements once per enabled clock. It flags completion with a one-cycle `done` pulse when the count reaches zero. It is the counting-down counterpart of the existing T-flip-flop up-counters and is built from the same toggle-cell style.

## Interface
- `WIDTH`, default 5: counter width; maximum run length is 2^WIDTH−1 enabled cycles.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `clr`, input, 1: reset, asynchronous, active-high; clock `clk`.
- `start`, input, 1: load request; samples `init` on a rising edge.
- `init`, input, WIDTH: initial count, unsigned.
- `en`, input, 1: decrement enable; ignored when not busy.
- `count`, output, WIDTH: current remaining count, registered.
- `busy`, output, 1: high while the count is nonzero and running.
- `done`, output, 1: registered one-cycle completion pulse.

## Operation
- Reset: while `clr` is high, `count` = 0, `busy` = 0, `done` = 0, and the reload register is 0. Assertion is immediate; release is synchronous to the next edge.
- States are implicit: IDLE (`busy` = 0) and RUN (`busy` = 1).
- Priority per edge, highest first: `clr`, then `start`, then decrement.
- `start` with `init` ≠ 0:
  - `count` ← `init`, `busy` ← 1, `done` ← 0.
  - `init` is also captured into the reload register.
- `start` with `init` = 0:
  - `count` ← 0, `busy` ← 0, `done` ← 1 for one cycle (zero-length run).
- `start` while busy: restarts from the new `init`. No `done` is issued for the aborted run, and no decrement occurs that cycle.
- Decrement happens when `busy` & `en` & !`start`:
  - `count` ← `count` − 1, modulo 2^WIDTH, implemented as a toggle chain.
  - Bit i toggles when all bits below i are 0; bit 0 always toggles.
- Terminal condition is a decrement with `count` = 1:
  - `count` ← 0, `busy` ← 0, `done` ← 1, all on the same edge.
- `done` is high for exactly one cycle, then returns to 0, unless another terminal or zero-length start occurs.
- `busy` & !`en`: `count` holds and `done` stays 0.
- IDLE with `count` = 0: `en` has no effect. The counter never wraps from 0 to all-ones.

## Timing
- Run length: `done` rises on the edge that applies the `init`-th enabled decrement after the load edge.
- Example: `init` = 3 with `en` held high gives load at edge 0, `count` 3→2→1→0 on edges 1–3, and `done` = 1 in the cycle after edge 3.
- Zero-length start: `done` is visible one cycle after the `start` edge.
- All outputs are registered. No combinational path exists from inputs to outputs.
- `clr` mid-run: outputs go to 0 immediately. The run is abandoned and no `done` is issued.

## Configuration
- `CYCLE_COUNTDOWN_RELOAD_EN` defined (periodic mode):
  - The terminal decrement loads `count` ← reload register, keeps `busy` = 1, and pulses `done`.
  - The period is `init` enabled cycles.
  - A `start` with `init` = 0 stops the timer: `busy` → 0 and one `done` pulse.
- `CYCLE_COUNTDOWN_RELOAD_EN` undefined (one-shot): behaviour is as in Operation. The reload register is omitted.

## Test plan
- Reset: assert `clr` mid-run at `count` = 4 → `count` = 0, `busy` = 0, `done` = 0 immediately. No `done` follows after release.
- Basic run: `start` with `init` = 5, `en` = 1 → `count` 5,4,3,2,1,0 on successive edges, `busy` falls with `count` = 0, and `done` is high for exactly 1 cycle.
- Gated enable: `init` = 3 with `en` toggling 1,0,1,0,1 → `count` holds on `en` = 0 edges and `done` arrives after the 3rd enabled edge.
- Restart and zero-length: `start` with `init` = 31 at `count` = 2 → `count` = 31 and no `done`. Then `start` with `init` = 0 → `busy` = 0 and `done` pulses once.
- Width boundary: `WIDTH` = 5, `init` = 16 → the 16→15 borrow toggles bits 0–4 correctly, and the run completes in 16 enabled cycles.
- Reload, with the macro defined: `init` = 2, `en` = 1 → `count` 2,1,2,1,…, `done` every 2 cycles, `busy` stays 1. Then `start` with `init` = 0 → stop with one `done`.

Source files
------------

// File: rtl/cycle_countdown.sv
// Loadable down-counter built from a toggle chain; pulses done when the count runs out.
// Define CYCLE_COUNTDOWN_RELOAD_EN for periodic mode (terminal count reloads the start value).
module cycle_countdown #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] init,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_count, w_next_count;
  logic [WIDTH-1:0] w_toggle;
  logic             r_done, w_next_done;
  logic             w_dec;
  logic             w_terminal;
`ifdef CYCLE_COUNTDOWN_RELOAD_EN
  logic [WIDTH-1:0] r_reload, w_next_reload;
`endif

  // Borrow ripple: bit i flips only when every lower bit is already 0.
  always_comb begin : toggle_chain
    logic w_borrow;
    w_borrow = 1'b1;
    w_toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_toggle[i] = w_borrow;
      w_borrow    = w_borrow & ~r_count[i];
    end
  end

  assign w_dec      = (r_state == RUN) && en && !start;
  assign w_terminal = w_dec && (r_count == WIDTH'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_done  = 1'b0;
`ifdef CYCLE_COUNTDOWN_RELOAD_EN
    w_next_reload = r_reload;
`endif
    if (start) begin
      if (init != '0) begin
        w_next_state = RUN;
        w_next_count = init;
`ifdef CYCLE_COUNTDOWN_RELOAD_EN
        w_next_reload = init;
`endif
      end else begin
        w_next_state = IDLE;
        w_next_count = '0;
        w_next_done  = 1'b1;
      end
    end else if (w_dec) begin
      w_next_count = r_count ^ w_toggle;
      if (w_terminal) begin
        w_next_done = 1'b1;
`ifdef CYCLE_COUNTDOWN_RELOAD_EN
        w_next_count = r_reload;
`else
        w_next_state = IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
`ifdef CYCLE_COUNTDOWN_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_done  <= w_next_done;
`ifdef CYCLE_COUNTDOWN_RELOAD_EN
      r_reload <= w_next_reload;
`endif
    end
  end

  assign count = r_count;
  assign busy  = (r_state == RUN);
  assign done  = r_done;

endmodule
